// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, ALU ops, FSM states, IR fields.
// Pure definitions; no timing or flow-control behaviour.
package cpu_pkg;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_BLT  = 4'hB;
  localparam logic [3:0] OP_BGE  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RD_MSB    = 8;
  localparam int RD_LSB    = 6;
  localparam int RT_MSB    = 5;
  localparam int RT_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_W     = 6;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SHL, ALU_SHR
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALTED
  } ctrl_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_branch_eval.sv
// Branch resolution from opcode and comparator flags; purely combinational, no backpressure.
module cpu_branch_eval
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  output logic       taken,
  output logic       is_branch
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (opcode)
      OP_BEQ:  taken = cmp_eq;
      OP_BNE:  taken = !cmp_eq;
      OP_BLT:  taken = cmp_lt;
      OP_BGE:  taken = !cmp_lt;
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control sequencer: branch 3, ALU/ADDI/SW 4, LW 5 cycles with zero-wait memory.
// Memory phases stall on mem_ready; a stall reaching MAX_WAIT halts the CPU with bus_err.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             mdr_load,
  output logic             alu_src_imm,
  output alu_op_e          alu_op,
  output logic             rf_we,
  output logic             rf_wsrc,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              taken, is_branch, is_mem_op, mem_phase, wait_expired, retire;

  cpu_branch_eval u_branch_eval (
    .opcode    (opcode),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .taken     (taken),
    .is_branch (is_branch)
  );

  assign is_mem_op    = (opcode == OP_LW) || (opcode == OP_SW);
  assign mem_phase    = (state == ST_FETCH) || (state == ST_MEM);
  assign wait_expired = mem_phase && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign retire = ((state == ST_EXEC) && is_branch) ||
                  ((state == ST_MEM) && mem_ready && (opcode == OP_SW)) ||
                  (state == ST_WB) ||
                  ((state == ST_DECODE) && (opcode == OP_HALT));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready)         state_nxt = ST_DECODE;
        else if (wait_expired) state_nxt = ST_HALTED;
      end
      ST_DECODE: begin
        if (!op_legal(opcode) || (opcode == OP_HALT)) state_nxt = ST_HALTED;
        else                                          state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_branch)      state_nxt = ST_FETCH;
        else if (is_mem_op) state_nxt = ST_MEM;
        else                state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)         state_nxt = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        else if (wait_expired) state_nxt = ST_HALTED;
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = ST_HALTED;
    endcase
  end

  // Strobes are forced low while reset is held even though the reset state is FETCH.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    mdr_load     = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    rf_wsrc      = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
        end
        ST_EXEC: begin
          if (is_branch) begin
            alu_op    = ALU_SUB;
            pc_branch = taken;
          end else if (opcode == OP_ALU) begin
            alu_op = alu_op_e'(funct);
          end else begin
            alu_src_imm = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_SW);
          mdr_load     = mem_ready && (opcode == OP_LW);
        end
        ST_WB: begin
          rf_we   = 1'b1;
          rf_wsrc = (opcode == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (mem_ready || (state_nxt != state) || !mem_phase) wait_cnt <= '0;
      else                                                 wait_cnt <= wait_cnt + 1'b1;
      if (retire)                                    retired <= retired + 1'b1;
      if ((state == ST_DECODE) && !op_legal(opcode)) illegal <= 1'b1;
      if (wait_expired)                              bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench: a small behavioural datapath and memory around cpu_ctrl_fsm.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic        cmp_eq, cmp_lt;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_branch, mdr_load;
  logic        alu_src_imm, rf_we, rf_wsrc, halted, illegal, bus_err;
  logic [2:0]  alu_op;
  logic [15:0] retired;
  logic [15:0] outs;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.CNT_W(16), .MAX_WAIT(255)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_branch(pc_branch), .mdr_load(mdr_load), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .rf_we(rf_we), .rf_wsrc(rf_wsrc), .halted(halted),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_branch, mdr_load,
                 alu_src_imm, rf_we, rf_wsrc, halted, illegal, bus_err, alu_op};

  // Datapath model: PC, IR, MDR, ALUOut, regfile and a 64-word memory.
  logic [15:0] mem [64];
  logic [15:0] regs [8];
  logic [15:0] pc, ir, mdr, aluout, addr, rdata, imm_sx, a_val, b_val, alu_res;
  int          brcnt;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
  assign imm_sx = {{(16-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign a_val  = regs[ir[RS_MSB:RS_LSB]];
  assign cmp_eq = (a_val == regs[ir[RD_MSB:RD_LSB]]);
  assign cmp_lt = ($signed(a_val) < $signed(regs[ir[RD_MSB:RD_LSB]]));
  assign b_val  = alu_src_imm ? imm_sx : regs[ir[RT_MSB:RT_LSB]];
  assign addr   = mem_addr_sel ? aluout : pc;
  assign rdata  = mem[addr[5:0]];

  always_comb begin
    case (alu_op)
      3'd0:    alu_res = a_val + b_val;
      3'd1:    alu_res = a_val - b_val;
      3'd2:    alu_res = a_val & b_val;
      3'd3:    alu_res = a_val | b_val;
      3'd4:    alu_res = a_val ^ b_val;
      3'd5:    alu_res = {15'd0, $signed(a_val) < $signed(b_val)};
      3'd6:    alu_res = a_val << b_val[3:0];
      default: alu_res = a_val >> b_val[3:0];
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      pc <= '0; ir <= '0; mdr <= '0; aluout <= '0; brcnt <= 0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (ir_load) ir <= rdata;
      if (pc_inc) pc <= pc + 16'd1;
      else if (pc_branch) pc <= pc + imm_sx;
      if (pc_branch) brcnt <= brcnt + 1;
      if (mdr_load) mdr <= rdata;
      if (!mem_req && !rf_we) aluout <= alu_res;
      if (rf_we && (ir[RD_MSB:RD_LSB] != 3'd0))
        regs[ir[RD_MSB:RD_LSB]] <= rf_wsrc ? mdr : aluout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 64; i++) mem[i] = 16'hF000;
  endtask

  // One reset edge, then release: on return the FSM is in its first FETCH cycle.
  task automatic rst_run();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int reqn, mdrn;

    // Reset state and ADDI R1,R0,5
    mem_fill();
    mem[0] = 16'h4045;
    mem_ready = 1'b1;
    reset = 1'b1;
    cyc(2);
    chk("reset_outs", 32'(outs), 0);
    chk("reset_retired", 32'(retired), 0);
    reset = 1'b0;
    #1;
    chk("addi_c1", {mem_req, mem_addr_sel, ir_load, pc_inc, rf_we}, 5'b10110);
    cyc();
    chk("addi_c2", {mem_req, rf_we, alu_src_imm}, 3'b000);
    cyc();
    chk("addi_c3", {rf_we, alu_src_imm, alu_op}, {1'b0, 1'b1, 3'd0});
    cyc();
    chk("addi_c4", {rf_we, rf_wsrc}, 2'b10);
    cyc();
    chk("addi_c5_rf_we", 32'(rf_we), 0);
    chk("addi_retired", 32'(retired), 1);
    chk("addi_r1", 32'(regs[1]), 32'h5);

    // BEQ taken (R1 == R2 == 0)
    mem_fill();
    mem[0] = 16'h9282;
    rst_run();
    cyc(2);
    chk("beq_taken_c3", {pc_branch, pc_inc, alu_op}, {1'b1, 1'b0, 3'd1});
    cyc();
    chk("beq_taken_pc", 32'(pc), 3);
    chk("beq_taken_retired", 32'(retired), 1);

    // BEQ not taken (R1 = 5)
    mem_fill();
    mem[0] = 16'h4045;
    mem[1] = 16'h9282;
    rst_run();
    cyc(6);
    chk("beq_nt_c7", {pc_branch, pc_inc}, 2'b00);
    cyc();
    chk("beq_nt_pc", 32'(pc), 2);
    chk("beq_nt_retired", 32'(retired), 2);

    // Full branch program
    mem_fill();
    mem[0]  = 16'h417F;  // ADDI R5,R0,-1
    mem[1]  = 16'h4181;  // ADDI R6,R0,1
    mem[2]  = 16'hBB81;  // BLT R5,R6,+1  taken
    mem[3]  = 16'h40C7;  // ADDI R3,R0,7  skipped
    mem[4]  = 16'hCD41;  // BGE R6,R5,+1  taken
    mem[5]  = 16'h40C2;  // ADDI R3,R0,2  skipped
    mem[6]  = 16'h40C1;  // ADDI R3,R0,1
    mem[7]  = 16'h9601;  // BEQ R3,R0,+1  not taken
    mem[8]  = 16'hA601;  // BNE R3,R0,+1  taken
    mem[9]  = 16'h40C3;  // ADDI R3,R0,3  skipped
    mem[10] = 16'h0B31;  // SUB R4,R5,R6
    mem[11] = 16'hF000;  // HALT
    rst_run();
    for (int i = 0; i < 200 && !halted; i++) cyc();
    chk("prog_halted", 32'(halted), 1);
    chk("prog_r3", 32'(regs[3]), 32'h0001);
    chk("prog_r4", 32'(regs[4]), 32'hFFFE);
    chk("prog_r5", 32'(regs[5]), 32'hFFFF);
    chk("prog_retired", 32'(retired), 9);
    chk("prog_branches", 32'(brcnt), 3);
    chk("prog_flags", {illegal, bus_err}, 2'b00);

    // LW R2,[R0+4] with three wait states in MEM
    mem_fill();
    mem[0] = 16'h5084;
    mem[4] = 16'hABCD;
    mem_ready = 1'b1;
    rst_run();
    cyc();
    mem_ready = 1'b0;
    cyc(2);
    reqn = 0;
    mdrn = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      reqn += int'(mem_req && mem_addr_sel && !mem_we);
      mdrn += int'(mdr_load);
      cyc();
    end
    chk("lw_wb", {mem_req, rf_we, rf_wsrc}, 3'b011);
    chk("lw_req_cycles", 32'(reqn), 4);
    chk("lw_mdr_loads", 32'(mdrn), 1);
    cyc();
    chk("lw_r2", 32'(regs[2]), 32'hABCD);
    chk("lw_retired", 32'(retired), 1);

    // SW with zero-wait memory
    mem_fill();
    mem[0] = 16'h6043;
    mem_ready = 1'b1;
    rst_run();
    cyc(3);
    chk("sw_c4", {mem_req, mem_we, mem_addr_sel}, 3'b111);
    cyc();
    chk("sw_c5", {mem_req, mem_we, 16'(retired)}, {2'b10, 16'd1});

    // Reset in the middle of a stalled SW memory phase
    mem_fill();
    mem[0] = 16'h4045;
    mem[1] = 16'h6043;
    mem_ready = 1'b1;
    rst_run();
    cyc(5);
    mem_ready = 1'b0;
    cyc(3);
    chk("midmem_c9", {mem_req, mem_we, mem_addr_sel, 16'(retired)}, {3'b111, 16'd1});
    reset = 1'b1;
    cyc();
    chk("midmem_reset_outs", 32'(outs), 0);
    chk("midmem_reset_retired", 32'(retired), 0);
    reset = 1'b0;
    #1;
    chk("midmem_fetch", {mem_req, mem_we, mem_addr_sel}, 3'b100);

    // Illegal opcode 0xE
    mem_fill();
    mem[0] = 16'hE000;
    mem_ready = 1'b1;
    rst_run();
    cyc(2);
    chk("illegal_c3", {halted, illegal, bus_err, rf_we, mem_req}, 5'b11000);
    chk("illegal_retired", 32'(retired), 0);
    cyc(3);
    chk("illegal_stays", {halted, rf_we, mem_req, ir_load}, 4'b1000);

    // Memory never ready in FETCH
    mem_fill();
    mem_ready = 1'b0;
    rst_run();
    cyc(255);
    chk("buserr_c256", {mem_req, halted, bus_err}, 3'b100);
    cyc();
    chk("buserr_c257", {mem_req, halted, bus_err, illegal}, 4'b0110);
    chk("buserr_retired", 32'(retired), 0);

    // mem_ready on the last allowed wait cycle is honoured
    mem_fill();
    mem_ready = 1'b0;
    rst_run();
    cyc(255);
    mem_ready = 1'b1;
    #1;
    chk("lastwait_c256", {ir_load, pc_inc, bus_err}, 3'b110);
    cyc(2);
    chk("lastwait_halt", {halted, bus_err, 16'(retired)}, {2'b10, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
